// File: rtl/lock_pkg.sv
// Shared types for the keypad lock: key identities, controller states and the
// 4-key code word with its power-on value.
package lock_pkg;

  typedef enum logic [1:0] {
    KEY_W = 2'd0,
    KEY_E = 2'd1,
    KEY_S = 2'd2,
    KEY_N = 2'd3
  } key_t;

  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_UNLOCKED,
    ST_PROG,
    ST_CONFIRM,
    ST_LOCKOUT
  } state_t;

  // Element [3] holds the first key entered, element [0] the last.
  typedef key_t [3:0] code_t;

  localparam code_t DEFAULT_CODE = code_t'({KEY_S, KEY_W, KEY_E, KEY_W});

endpackage

// File: rtl/lock_code_ctrl_if.sv
// Keypad-side and status signals of the lock controller, bundled for the top.
interface lock_code_ctrl_if;

  logic       key_valid;
  logic [1:0] key_code;
  logic       prog_req;
  logic       unlocked;
  logic       alarm;
  logic       prog_mode;
  logic [2:0] digit_cnt;
  logic [1:0] fail_cnt;
  logic       prog_ok;
  logic       prog_err;

  modport master (
    output key_valid, key_code, prog_req,
    input  unlocked, alarm, prog_mode, digit_cnt, fail_cnt, prog_ok, prog_err
  );

  modport slave (
    input  key_valid, key_code, prog_req,
    output unlocked, alarm, prog_mode, digit_cnt, fail_cnt, prog_ok, prog_err
  );

endinterface

// File: rtl/code_entry_reg.sv
// Four-key entry shift register with digit count; full once four keys are held
// and stays full until cleared, so extra keys are dropped.
module code_entry_reg
  import lock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       shift,
  input  logic       clr,
  input  key_t       key,
  output code_t      code,
  output logic [2:0] cnt,
  output logic       full
);

  assign full = (cnt == 3'd4);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 3'd0;
    end else if (shift && !full) begin
      cnt <= cnt + 3'd1;
    end
  end

  // Digits are only meaningful while cnt says so; no reset needed.
  always_ff @(posedge clk) begin
    if (shift && !clr && !full) begin
      code <= code_t'({code[2:0], key});
    end
  end

endmodule

// File: rtl/lock_code_ctrl.sv
// Keypad code lock: 4-key unlock, consecutive-failure lockout with timed alarm,
// and a two-pass (enter + confirm) code change mode.
module lock_code_ctrl
  import lock_pkg::*;
#(
  parameter int clk_freq    = 125_000_000,
  parameter int lockout_sec = 1,
  parameter int max_fail    = 3
) (
  input logic             clk,
  input logic             rst,
  lock_code_ctrl_if.slave bus
);

  localparam int LOCKOUT_CYCLES = clk_freq * lockout_sec;
  localparam int TMR_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0] FAIL_LIM = 3'(max_fail);

  state_t           state, state_n;
  logic [1:0]       fail_cnt, fail_n;
  logic [2:0]       fail_inc;
  logic [TMR_W-1:0] timer, timer_n;
  code_t            code, code_n;
  code_t            shadow, shadow_n;
  code_t            entry;
  logic             ok, ok_n, err, err_n;
  logic             shift, clr, full;
  logic [2:0]       cnt;
  key_t             key;

  assign key      = key_t'(bus.key_code);
  assign fail_inc = {1'b0, fail_cnt} + 3'd1;

  code_entry_reg u_entry (
    .clk   (clk),
    .rst   (rst),
    .shift (shift),
    .clr   (clr),
    .key   (key),
    .code  (entry),
    .cnt   (cnt),
    .full  (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_LOCKED;
      fail_cnt <= 2'd0;
      timer    <= '0;
      code     <= DEFAULT_CODE;
      ok       <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      fail_cnt <= fail_n;
      timer    <= timer_n;
      code     <= code_n;
      ok       <= ok_n;
      err      <= err_n;
    end
  end

  // Shadow is always fully rewritten in PROG before CONFIRM reads it.
  always_ff @(posedge clk) begin
    shadow <= shadow_n;
  end

  always_comb begin
    state_n  = state;
    fail_n   = fail_cnt;
    timer_n  = timer;
    code_n   = code;
    shadow_n = shadow;
    ok_n     = 1'b0;
    err_n    = 1'b0;
    shift    = 1'b0;
    clr      = 1'b0;
    unique case (state)
      ST_LOCKED: begin
        shift = bus.key_valid && !full;
        if (full) begin
          clr = 1'b1;
          if (entry == code) begin
            state_n = ST_UNLOCKED;
            fail_n  = 2'd0;
          end else if (fail_inc >= FAIL_LIM) begin
            // fail_cnt is already at max_fail-1 here and is left saturated.
            state_n = ST_LOCKOUT;
            timer_n = TMR_LOAD;
          end else begin
            fail_n = fail_inc[1:0];
          end
        end
      end
      ST_UNLOCKED: begin
        if (bus.prog_req) begin
          state_n = ST_PROG;
          clr     = 1'b1;
        end else if (bus.key_valid && key == KEY_N) begin
          state_n = ST_LOCKED;
        end
      end
      ST_PROG: begin
        shift = bus.key_valid && !full;
        if (full) begin
          clr      = 1'b1;
          shadow_n = entry;
          state_n  = ST_CONFIRM;
        end
      end
      ST_CONFIRM: begin
        shift = bus.key_valid && !full;
        if (full) begin
          clr     = 1'b1;
          state_n = ST_UNLOCKED;
          if (entry == shadow) begin
            code_n = entry;
            ok_n   = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_LOCKOUT: begin
        clr = 1'b1;
        if (timer == '0) begin
          state_n = ST_LOCKED;
          fail_n  = 2'd0;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: state_n = ST_LOCKED;
    endcase
  end

  assign bus.unlocked  = (state == ST_UNLOCKED) || (state == ST_PROG) || (state == ST_CONFIRM);
  assign bus.alarm     = (state == ST_LOCKOUT);
  assign bus.prog_mode = (state == ST_PROG) || (state == ST_CONFIRM);
  assign bus.digit_cnt = cnt;
  assign bus.fail_cnt  = fail_cnt;
  assign bus.prog_ok   = ok;
  assign bus.prog_err  = err;

endmodule

// File: doc/lock_code_ctrl.md
LOCK_CODE_CTRL -- requirements
Module: lock_code_ctrl

Interface
REQ-001 The block SHALL have parameter clk_freq, default 125_000_000, giving the clock frequency in Hz.
REQ-002 The block SHALL have parameter lockout_sec, default 1, giving the lockout duration in seconds; lockout length is LOCKOUT_CYCLES = clk_freq*lockout_sec.
REQ-003 The block SHALL have parameter max_fail, default 3, giving the number of consecutive wrong codes that triggers lockout.
REQ-004 clk  input  1  system clock; the block uses one clock only.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 key_valid  input  1  one-cycle pulse, already debounced, marking one key press.
REQ-007 key_code  input  2  key identity: 3=N, 2=S, 1=E, 0=W (btn bit index).
REQ-008 prog_req  input  1  one-cycle pulse requesting code-change mode.
REQ-009 unlocked  output  1  high in UNLOCKED, PROG and CONFIRM.
REQ-010 alarm  output  1  high in LOCKOUT.
REQ-011 prog_mode  output  1  high in PROG and CONFIRM.
REQ-012 digit_cnt  output  3  number of digits captured in the current entry, 0..4.
REQ-013 fail_cnt  output  2  count of consecutive failed attempts.
REQ-014 prog_ok  output  1  one-cycle pulse when a new code is committed.
REQ-015 prog_err  output  1  one-cycle pulse when the confirm entry mismatches.

Function
REQ-016 The states SHALL be LOCKED, UNLOCKED, PROG, CONFIRM and LOCKOUT; the stored code SHALL be 4 keys.
REQ-017 In LOCKED, each key_valid SHALL shift key_code into the entry register and increment digit_cnt.
REQ-018 In LOCKED, the code SHALL be compared only after the 4th digit; there is no early abort.
REQ-019 On the 4th digit, the comparison result SHALL take effect on the next clock edge, and digit_cnt SHALL clear to 0.
REQ-020 On a match, the block SHALL go to UNLOCKED and clear fail_cnt.
REQ-021 On a mismatch with fail_cnt+1 < max_fail, the block SHALL increment fail_cnt and stay in LOCKED.
REQ-022 On a mismatch with fail_cnt+1 = max_fail, the block SHALL go to LOCKOUT and load the timer with LOCKOUT_CYCLES-1.
REQ-023 In LOCKOUT, keys and prog_req SHALL be ignored and the timer SHALL decrement every cycle.
REQ-024 At timer 0, the block SHALL go to LOCKED and clear fail_cnt and digit_cnt.
REQ-025 In UNLOCKED, key N SHALL go to LOCKED, and all other keys SHALL be ignored.
REQ-026 In UNLOCKED, prog_req SHALL go to PROG; if prog_req and key_valid arrive in the same cycle, prog_req SHALL win and the key SHALL be dropped.
REQ-027 PROG SHALL capture 4 keys, including N, into a shadow register, then go to CONFIRM with digit_cnt cleared.
REQ-028 CONFIRM SHALL capture 4 keys; a match with the shadow SHALL commit the code, pulse prog_ok and return to UNLOCKED.
REQ-029 A mismatch in CONFIRM SHALL leave the stored code unchanged, pulse prog_err and return to UNLOCKED.
REQ-030 prog_req outside UNLOCKED SHALL be ignored.
REQ-031 key_valid while key_code is stable across several cycles SHALL count once per pulse only.
REQ-032 fail_cnt SHALL saturate at max_fail-1 and never wrap.

Reset
REQ-033 rst SHALL force state LOCKED, digit_cnt=0, fail_cnt=0, timer=0, prog_ok=0 and prog_err=0.
REQ-034 rst SHALL restore the stored code to DEFAULT_CODE = S,W,E,W.
REQ-035 rst mid-entry, mid-PROG or mid-LOCKOUT SHALL discard partial entries and any uncommitted shadow code.

Structure
REQ-036 Package lock_pkg SHALL hold the key_t enum (N/S/E/W), the state_t enum, the code_t type (4 x key_t) and DEFAULT_CODE.
REQ-037 One sub-module, code_entry_reg, SHALL implement a 4-digit shift register with count, clear input and full flag; it is instanced once and shared by LOCKED, PROG and CONFIRM.
REQ-038 The lockout timer width SHALL be $clog2(LOCKOUT_CYCLES).

Verification (bench: clk_freq=100, lockout_sec=1, so lockout is 100 cycles)
REQ-039 Keys S,W,E,W after reset -> unlocked=1 one cycle after the 4th key, fail_cnt=0.
REQ-040 Keys S,W,E,E then S,W,E,W -> fail_cnt=1 after the first entry, then unlocked=1.
REQ-041 Three wrong codes -> alarm=1 for exactly 100 cycles, keys ignored meanwhile, then LOCKED with fail_cnt=0.
REQ-042 Unlocked, prog_req, then N,N,E,W twice, then key N, then N,N,E,W -> prog_ok pulse, relock, unlock on the new code.
REQ-043 Unlocked, prog_req, then N,N,E,W followed by N,N,E,S -> prog_err pulse, and the old code S,W,E,W still unlocks.
REQ-044 rst asserted after 2 entered digits or during LOCKOUT -> digit_cnt=0, alarm=0, and DEFAULT_CODE unlocks.
